// File: rtl/apb_pkg.sv
// Shared APB slave definitions: bus widths, FSM encoding and special word indices.
package apb_pkg;

    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_AW = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] REG_WAIT  = 4'd14;
    localparam logic [3:0] REG_COUNT = 4'd15;

    typedef logic [APB_DW-1:0] apb_data_t;
    typedef logic [APB_AW-1:0] apb_addr_t;

endpackage

// File: rtl/apb_regfile.sv
// 16-word register file: 14 general words, 4-bit WAIT field and read-only transfer COUNT.
module apb_regfile
    import apb_pkg::*;
#(
    parameter logic [3:0] WAIT_RESET = 4'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [3:0]      waddr,
    input  apb_data_t       wdata,
    input  logic            inc,
    input  logic [3:0]      raddr,
    output apb_data_t       rdata,
    output logic [3:0]      wait_val
);

    apb_data_t  gp_q [0:13];
    logic [3:0] wait_q;
    apb_data_t  count_q;

    // COUNT only ever follows inc, so a same-edge write to it is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 14; i++) begin
                gp_q[i] <= '0;
            end
            wait_q  <= WAIT_RESET;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 14; i++) begin
                if (we && (waddr == 4'(i))) begin
                    gp_q[i] <= wdata;
                end
            end
            if (we && (waddr == REG_WAIT)) begin
                wait_q <= wdata[3:0];
            end
            if (inc) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            if (raddr == 4'(i)) begin
                rdata = gp_q[i];
            end
        end
        if (raddr == REG_WAIT) begin
            rdata = {28'd0, wait_q};
        end
        if (raddr == REG_COUNT) begin
            rdata = count_q;
        end
    end

    assign wait_val = wait_q;

endmodule

// File: rtl/apb_wait_slave.sv
// APB slave with programmable wait states; owns the transfer FSM and registered outputs.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [3:0]  WAIT_STATES = 4'd2
) (
    input  logic        Pclk,
    input  logic        Preset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pdata,
    output logic [31:0] Prdata,
    output logic        Pready
);

    logic [1:0] state_q;
    logic [3:0] cnt_q;
    logic       hit;
    logic       setup;
    logic       complete;
    logic       rf_we;
    apb_data_t  rf_rdata;
    apb_data_t  rd_word;
    logic [3:0] wait_val;
    logic       unused_addr_bits;

    assign hit      = (Paddr[31:6] == BASE_ADDR[31:6]);
    assign setup    = Psel & ~Penable;
    assign complete = (state_q == ST_DONE) & Psel & Penable & Pready;
    assign rf_we    = complete & Pwrite & hit;
    assign rd_word  = hit ? rf_rdata : '0;
    assign unused_addr_bits = ^Paddr[1:0];

    apb_regfile #(
        .WAIT_RESET (WAIT_STATES)
    ) u_regfile (
        .clk      (Pclk),
        .rst      (Preset),
        .we       (rf_we),
        .waddr    (Paddr[5:2]),
        .wdata    (Pdata),
        .inc      (complete),
        .raddr    (Paddr[5:2]),
        .rdata    (rf_rdata),
        .wait_val (wait_val)
    );

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            Prdata  <= '0;
            Pready  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    Pready <= 1'b0;
                    if (setup) begin
                        cnt_q <= wait_val;
                        if (wait_val == 4'd0) begin
                            state_q <= ST_DONE;
                            Pready  <= 1'b1;
                            if (!Pwrite) begin
                                Prdata <= rd_word;
                            end
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!Psel) begin
                        state_q <= ST_IDLE;
                        Pready  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_q <= ST_DONE;
                            Pready  <= 1'b1;
                            if (!Pwrite) begin
                                Prdata <= rd_word;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    // Completion and abort both leave DONE; commit/count hang off 'complete'.
                    state_q <= ST_IDLE;
                    Pready  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    Pready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: read expectations queued at setup, checked at Pready.
module tb_apb_wait_slave;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        Pclk = 1'b0;
    logic        Preset = 1'b0;
    logic        Psel = 1'b0;
    logic        Penable = 1'b0;
    logic        Pwrite = 1'b0;
    logic [31:0] Paddr = '0;
    logic [31:0] Pdata = '0;
    logic [31:0] Prdata;
    logic        Pready;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:13];
    logic [3:0]  model_wait;
    logic [31:0] model_count;
    logic [31:0] exp_q [$];
    time         last_done_t;

    apb_wait_slave #(
        .BASE_ADDR   (BASE),
        .WAIT_STATES (4'd2)
    ) dut (
        .Pclk    (Pclk),
        .Preset  (Preset),
        .Psel    (Psel),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Paddr   (Paddr),
        .Pdata   (Pdata),
        .Prdata  (Prdata),
        .Pready  (Pready)
    );

    always #5 Pclk = ~Pclk;

    function automatic logic [31:0] model_read(input logic h, input logic [3:0] idx);
        if (!h) return 32'h0;
        if (idx == 4'd14) return {28'd0, model_wait};
        if (idx == 4'd15) return model_count;
        return model_mem[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 14; i++) model_mem[i] = '0;
        model_wait  = 4'd2;
        model_count = '0;
        exp_q.delete();
    endtask

    task automatic bus_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Pclk);
            Psel = 1'b0;
            Penable = 1'b0;
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int cyc;
        int exp_cyc;
        logic h;
        logic [3:0] idx;
        logic [31:0] exp_rd;
        h   = (addr[31:6] == BASE[31:6]);
        idx = addr[5:2];
        @(negedge Pclk);
        checks++;
        if (Pready !== 1'b0) begin
            errors++;
            $display("FAIL pready_low_before_setup: got %b expected 0", Pready);
        end
        Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pdata = data;
        exp_cyc = int'(model_wait) + 1;
        if (!wr) exp_q.push_back(model_read(h, idx));
        @(negedge Pclk);
        Penable = 1'b1;
        cyc = 1;
        while (Pready !== 1'b1 && cyc < 40) begin
            @(negedge Pclk);
            cyc++;
        end
        checks++;
        if (Pready !== 1'b1) begin
            errors++;
            $display("FAIL pready_timeout addr %h: got %b expected 1 within 40 cycles", addr, Pready);
            if (!wr) void'(exp_q.pop_front());
            Psel = 1'b0; Penable = 1'b0;
            return;
        end
        last_done_t = $time;
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL access_cycles addr %h: got %0d expected %0d", addr, cyc, exp_cyc);
        end
        if (!wr) begin
            exp_rd = exp_q.pop_front();
            checks++;
            if (Prdata !== exp_rd) begin
                errors++;
                $display("FAIL read_data addr %h: got %h expected %h", addr, Prdata, exp_rd);
            end
        end
        // completion happens on the coming rising edge
        if (wr && h) begin
            if (idx < 4'd14) model_mem[idx] = data;
            else if (idx == 4'd14) model_wait = data[3:0];
        end
        model_count = model_count + 32'd1;
    endtask

    task automatic test_reset();
        Preset = 1'b1;
        repeat (3) @(negedge Pclk);
        checks++;
        if (Pready !== 1'b0) begin
            errors++;
            $display("FAIL reset_pready: got %b expected 0", Pready);
        end
        checks++;
        if (Prdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_prdata: got %h expected 0", Prdata);
        end
        Preset = 1'b0;
        model_reset();
    endtask

    task automatic test_read_wait();
        apb_xfer(1'b0, BASE + 32'h38, '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        bus_idle(1);
    endtask

    task automatic test_write_read();
        apb_xfer(1'b1, BASE + 32'h0C, 32'hDEAD_BEEF);
        apb_xfer(1'b0, BASE + 32'h0C, '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        time prev_t;
        apb_xfer(1'b1, BASE + 32'h38, 32'h0);
        bus_idle(1);
        for (int i = 0; i < 4; i++) begin
            apb_xfer(1'b0, BASE + 32'(i * 4), '0);
            if (i > 0) begin
                checks++;
                if ((last_done_t - prev_t) != 20) begin
                    errors++;
                    $display("FAIL b2b_period %0d: got %0t expected 20", i, last_done_t - prev_t);
                end
            end
            prev_t = last_done_t;
        end
        bus_idle(1);
    endtask

    task automatic test_miss();
        apb_xfer(1'b1, BASE + 32'h40, 32'h1234_5678);
        apb_xfer(1'b0, BASE + 32'h40, '0);
        for (int i = 0; i < 14; i++) apb_xfer(1'b0, BASE + 32'(i * 4), '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        bus_idle(1);
    endtask

    task automatic test_abort();
        apb_xfer(1'b1, BASE + 32'h38, 32'h5);
        @(negedge Pclk);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h1C; Pdata = 32'hA5A5_A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge Pclk);
            checks++;
            if (Pready !== 1'b0) begin
                errors++;
                $display("FAIL abort_pready cycle %0d: got %b expected 0", i, Pready);
            end
            if (i == 0) Penable = 1'b1;
            if (i == 2) begin Psel = 1'b0; Penable = 1'b0; end
        end
        @(negedge Pclk);
        checks++;
        if (Pready !== 1'b0) begin
            errors++;
            $display("FAIL abort_pready_after: got %b expected 0", Pready);
        end
        apb_xfer(1'b0, BASE + 32'h1C, '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        bus_idle(1);
    endtask

    task automatic test_count_wrap();
        apb_xfer(1'b1, BASE + 32'h38, 32'h2);
        @(negedge Pclk);
        Psel = 1'b0; Penable = 1'b0;
        force dut.u_regfile.count_q = 32'hFFFF_FFFF;
        @(negedge Pclk);
        release dut.u_regfile.count_q;
        model_count = 32'hFFFF_FFFF;
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        apb_xfer(1'b0, BASE + 32'h0C, '0);
        bus_idle(1);
    endtask

    task automatic test_reset_mid();
        @(negedge Pclk);
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = BASE + 32'h0C;
        @(negedge Pclk);
        Penable = 1'b1;
        @(negedge Pclk);
        Preset = 1'b1;
        #1;
        checks++;
        if (Pready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pready: got %b expected 0", Pready);
        end
        checks++;
        if (Prdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_prdata: got %h expected 0", Prdata);
        end
        Psel = 1'b0; Penable = 1'b0;
        @(negedge Pclk);
        Preset = 1'b0;
        model_reset();
        apb_xfer(1'b0, BASE + 32'h38, '0);
        apb_xfer(1'b0, BASE + 32'h0C, '0);
        apb_xfer(1'b0, BASE + 32'h3C, '0);
        bus_idle(2);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_read_wait();
        test_write_read();
        test_back_to_back();
        test_miss();
        test_abort();
        test_count_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
